// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the IF-stage branch target buffer:
// direction-counter encodings and default geometry.
package branch_predictor_pkg;

    // 2-bit direction counter encodings (strongly/weakly not-taken/taken).
    localparam logic [1:0] BP_CTR_SNT = 2'b00;
    localparam logic [1:0] BP_CTR_WNT = 2'b01;
    localparam logic [1:0] BP_CTR_WT  = 2'b10;
    localparam logic [1:0] BP_CTR_ST  = 2'b11;

    // Default BTB geometry.
    localparam int BP_DEFAULT_ENTRIES = 64;
    localparam int BP_DEFAULT_TAG_W   = 6;

endpackage

// File: rtl/bp_sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
// Priority: load > force-to-strongly-taken > increment > decrement.
module bp_sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       load_i,
    input  logic [1:0] load_val_i,
    input  logic       force_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] ctr_o
);

    // Select the counter's next value; saturate at both ends.
    always_comb begin
        // NOTE: ctr_o gets a default first so no path leaves it unassigned (no latch).
        ctr_o = ctr_i;
        if (load_i) begin
            ctr_o = load_val_i;
        end else if (force_i) begin
            ctr_o = BP_CTR_ST;
        end else if (inc_i) begin
            if (ctr_i != BP_CTR_ST) ctr_o = ctr_i + 2'd1;
        end else if (dec_i) begin
            if (ctr_i != BP_CTR_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Predicts the next PC combinationally from the IF-stage PC and is trained
// from EX-stage resolved outcomes; also keeps saturating lookup and
// misprediction statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         ENTRIES  = BP_DEFAULT_ENTRIES,
    parameter int         TAG_W    = BP_DEFAULT_TAG_W,
    parameter int         CNT_W    = 32,
    parameter logic [1:0] INIT_CTR = BP_CTR_WNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_i,
    input  logic              lookup_en_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [31:0]       pred_npc_o,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [31:0]       upd_target_i,
    input  logic              upd_uncond_i,
    input  logic              upd_mispred_i,
    input  logic              flush_i,
    input  logic              stats_clr_i,
    output logic [CNT_W-1:0]  stat_lookups_o,
    output logic [CNT_W-1:0]  stat_mispred_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_HI = IDX_W + TAG_W + 1;

    // Per-entry state: valid bits and counters need a parallel clear on
    // flush, so they live in flops; tags and targets are plain storage.
    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic             wr_en    [ENTRIES];

    logic [CNT_W-1:0] lookups_q, lookups_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    // Lookup and update address fields.
    logic [IDX_W-1:0] pred_idx, upd_idx;
    logic [TAG_W-1:0] pred_tag, upd_tag;
    logic             upd_hit;
    logic             upd_taken_eff;
    logic             upd_alloc;

    assign pred_idx = pc_i[IDX_W+1:2];
    assign pred_tag = pc_i[TAG_HI:IDX_W+2];
    assign upd_idx  = upd_pc_i[IDX_W+1:2];
    assign upd_tag  = upd_pc_i[TAG_HI:IDX_W+2];

    // Bits of the PCs that take no part in indexing or tagging.
    logic unused_pc_bits;
    generate
        if (TAG_HI < 31) begin : g_unused_hi
            assign unused_pc_bits = ^{pc_i[31:TAG_HI+1], pc_i[1:0],
                                      upd_pc_i[31:TAG_HI+1], upd_pc_i[1:0]};
        end else begin : g_unused_lo
            assign unused_pc_bits = ^{pc_i[1:0], upd_pc_i[1:0]};
        end
    endgenerate

    // Combinational prediction from the current (pre-update) contents.
    always_comb begin
        pred_hit_o   = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
        pred_taken_o = pred_hit_o && ctr_q[pred_idx][1];
        pred_npc_o   = pred_taken_o ? target_q[pred_idx] : pc_i + 32'd4;
    end

    // Classify the incoming update against the addressed entry.
    always_comb begin
        upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_taken_eff = upd_taken_i || upd_uncond_i;
        upd_alloc     = upd_taken_eff && !upd_hit;
    end

    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
            logic sel;
            logic ctr_load;
            logic [1:0] ctr_load_val;
            logic ctr_force;
            logic ctr_inc;
            logic ctr_dec;

            assign sel = upd_valid_i && (upd_idx == IDX_W'(i));

            // Flush wins over everything; allocation starts weakly taken
            // unless the transfer is unconditional.
            assign ctr_load     = flush_i || (sel && upd_alloc && !upd_uncond_i);
            assign ctr_load_val = flush_i ? INIT_CTR : BP_CTR_WT;
            assign ctr_force    = sel && upd_uncond_i;
            assign ctr_inc      = sel && upd_hit && upd_taken_eff;
            assign ctr_dec      = sel && upd_hit && !upd_taken_eff;

            bp_sat_counter2 u_ctr (
                .ctr_i      (ctr_q[i]),
                .load_i     (ctr_load),
                .load_val_i (ctr_load_val),
                .force_i    (ctr_force),
                .inc_i      (ctr_inc),
                .dec_i      (ctr_dec),
                .ctr_o      (ctr_d[i])
            );

            assign valid_d[i] = flush_i ? 1'b0 : ((sel && upd_taken_eff) ? 1'b1 : valid_q[i]);
            assign wr_en[i]   = sel && upd_taken_eff;
        end
    endgenerate

    // Register valid bits and direction counters; reset loads the idle state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= INIT_CTR;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= valid_d[i];
                ctr_q[i]   <= ctr_d[i];
            end
        end
    end

    // Write tag and target on taken updates (hit refresh or allocation).
    always_ff @(posedge clk) begin
        // NOTE: tags/targets are not reset; the cleared valid bits make their contents irrelevant.
        for (int i = 0; i < ENTRIES; i++) begin
            if (wr_en[i]) begin
                tag_q[i]    <= upd_tag;
                target_q[i] <= upd_target_i;
            end
        end
    end

    // Next values of the saturating statistics counters; clear wins.
    always_comb begin
        lookups_d = lookups_q;
        mispred_d = mispred_q;
        if (stats_clr_i) begin
            lookups_d = '0;
            mispred_d = '0;
        end else begin
            if (lookup_en_i && !(&lookups_q)) lookups_d = lookups_q + CNT_W'(1);
            if (upd_valid_i && upd_mispred_i && !(&mispred_q)) mispred_d = mispred_q + CNT_W'(1);
        end
    end

    // Register the statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            lookups_q <= lookups_d;
            mispred_q <= mispred_d;
        end
    end

    assign stat_lookups_o = lookups_q;
    assign stat_mispred_o = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a vector table for training and
// prediction, plus hand-written sequences for same-cycle read/write,
// flush, statistics saturation and mid-run reset.
module tb_branch_predictor;

    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       pc_i;
    logic              lookup_en_i;
    logic              pred_hit_o;
    logic              pred_taken_o;
    logic [31:0]       pred_npc_o;
    logic              upd_valid_i;
    logic [31:0]       upd_pc_i;
    logic              upd_taken_i;
    logic [31:0]       upd_target_i;
    logic              upd_uncond_i;
    logic              upd_mispred_i;
    logic              flush_i;
    logic              stats_clr_i;
    logic [CNT_W-1:0]  stat_lookups_o;
    logic [CNT_W-1:0]  stat_mispred_o;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor #(
        .ENTRIES (64),
        .TAG_W   (6),
        .CNT_W   (CNT_W),
        .INIT_CTR(2'b01)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc_i),
        .lookup_en_i    (lookup_en_i),
        .pred_hit_o     (pred_hit_o),
        .pred_taken_o   (pred_taken_o),
        .pred_npc_o     (pred_npc_o),
        .upd_valid_i    (upd_valid_i),
        .upd_pc_i       (upd_pc_i),
        .upd_taken_i    (upd_taken_i),
        .upd_target_i   (upd_target_i),
        .upd_uncond_i   (upd_uncond_i),
        .upd_mispred_i  (upd_mispred_i),
        .flush_i        (flush_i),
        .stats_clr_i    (stats_clr_i),
        .stat_lookups_o (stat_lookups_o),
        .stat_mispred_o (stat_mispred_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic        upd_uncond;
        logic [31:0] pc;
        logic        exp_hit;
        logic        exp_taken;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pred(input string name, input logic hit, input logic taken, input logic [31:0] npc);
        check({name, "_hit"},   32'(pred_hit_o),   32'(hit));
        check({name, "_taken"}, 32'(pred_taken_o), 32'(taken));
        check({name, "_npc"},   pred_npc_o,        npc);
    endtask

    task automatic idle_inputs();
        lookup_en_i   = 1'b0;
        upd_valid_i   = 1'b0;
        upd_pc_i      = 32'h0;
        upd_taken_i   = 1'b0;
        upd_target_i  = 32'h0;
        upd_uncond_i  = 1'b0;
        upd_mispred_i = 1'b0;
        flush_i       = 1'b0;
        stats_clr_i   = 1'b0;
    endtask

    initial begin
        // upd_valid, upd_pc, taken, target, uncond | lookup pc, hit, taken, npc
        vecs[0]  = '{1'b1, 32'h8010, 1'b1, 32'h8100, 1'b0, 32'h8010, 1'b1, 1'b1, 32'h8100};
        vecs[1]  = '{1'b1, 32'h8010, 1'b0, 32'h0,    1'b0, 32'h8010, 1'b1, 1'b0, 32'h8014};
        vecs[2]  = '{1'b1, 32'h8010, 1'b1, 32'h8100, 1'b0, 32'h8010, 1'b1, 1'b1, 32'h8100};
        vecs[3]  = '{1'b1, 32'h8010, 1'b1, 32'h8100, 1'b0, 32'h8010, 1'b1, 1'b1, 32'h8100};
        vecs[4]  = '{1'b1, 32'h8010, 1'b1, 32'h8100, 1'b0, 32'h8010, 1'b1, 1'b1, 32'h8100};
        vecs[5]  = '{1'b1, 32'h8010, 1'b1, 32'h8100, 1'b0, 32'h8010, 1'b1, 1'b1, 32'h8100};
        vecs[6]  = '{1'b1, 32'h8010, 1'b0, 32'h0,    1'b0, 32'h8010, 1'b1, 1'b1, 32'h8100};
        vecs[7]  = '{1'b1, 32'h8020, 1'b1, 32'h9000, 1'b1, 32'h8020, 1'b1, 1'b1, 32'h9000};
        vecs[8]  = '{1'b1, 32'h8020, 1'b0, 32'h0,    1'b0, 32'h8020, 1'b1, 1'b1, 32'h9000};
        vecs[9]  = '{1'b1, 32'h8110, 1'b1, 32'h8200, 1'b0, 32'h8110, 1'b1, 1'b1, 32'h8200};
        vecs[10] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h8010, 1'b0, 1'b0, 32'h8014};
        vecs[11] = '{1'b1, 32'h8030, 1'b0, 32'h7777, 1'b0, 32'h8030, 1'b0, 1'b0, 32'h8034};
        vecs[12] = '{1'b1, 32'h8010, 1'b0, 32'h0,    1'b0, 32'h8110, 1'b1, 1'b1, 32'h8200};
        vecs[13] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 32'h8110, 1'b1, 32'h8300, 1'b0, 32'h8110, 1'b1, 1'b1, 32'h8300};
        vecs[15] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h8112, 1'b1, 1'b1, 32'h8300};

        // Reset and idle prediction.
        idle_inputs();
        rst  = 1'b1;
        pc_i = 32'h8000;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check_pred("reset", 1'b0, 1'b0, 32'h8004);
        check("reset_lookups", 32'(stat_lookups_o), 32'd0);
        check("reset_mispred", 32'(stat_mispred_o), 32'd0);

        // Training / prediction table.
        for (int i = 0; i < 16; i++) begin
            upd_valid_i  = vecs[i].upd_valid;
            upd_pc_i     = vecs[i].upd_pc;
            upd_taken_i  = vecs[i].upd_taken;
            upd_target_i = vecs[i].upd_target;
            upd_uncond_i = vecs[i].upd_uncond;
            tick();
            upd_valid_i  = 1'b0;
            upd_uncond_i = 1'b0;
            pc_i         = vecs[i].pc;
            #1;
            check_pred($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_taken, vecs[i].exp_npc);
        end

        // Same-cycle read and write: prediction shows old contents first.
        pc_i         = 32'h8040;
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h8040;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'hA000;
        #1;
        check_pred("rw_before", 1'b0, 1'b0, 32'h8044);
        tick();
        upd_valid_i = 1'b0;
        #1;
        check_pred("rw_after", 1'b1, 1'b1, 32'hA000);

        // Three counted lookups.
        lookup_en_i = 1'b1;
        repeat (3) tick();
        lookup_en_i = 1'b0;
        check("lookups_3", 32'(stat_lookups_o), 32'd3);

        // Flush together with a mispredicted update: flush wins, stats kept.
        flush_i       = 1'b1;
        upd_valid_i   = 1'b1;
        upd_pc_i      = 32'h8050;
        upd_taken_i   = 1'b1;
        upd_target_i  = 32'hB000;
        upd_mispred_i = 1'b1;
        tick();
        idle_inputs();
        pc_i = 32'h8050;
        #1;
        check_pred("flush_upd", 1'b0, 1'b0, 32'h8054);
        pc_i = 32'h8110;
        #1;
        check_pred("flush_alias", 1'b0, 1'b0, 32'h8114);
        pc_i = 32'h8040;
        #1;
        check_pred("flush_rw", 1'b0, 1'b0, 32'h8044);
        check("flush_lookups", 32'(stat_lookups_o), 32'd3);
        check("flush_mispred", 32'(stat_mispred_o), 32'd1);

        // Clear wins over a same-cycle lookup.
        stats_clr_i = 1'b1;
        lookup_en_i = 1'b1;
        tick();
        idle_inputs();
        check("clr_lookups", 32'(stat_lookups_o), 32'd0);
        check("clr_mispred", 32'(stat_mispred_o), 32'd0);

        // Lookup counter saturates at 15 with a 4-bit width.
        lookup_en_i = 1'b1;
        repeat (20) tick();
        lookup_en_i = 1'b0;
        check("lookups_sat", 32'(stat_lookups_o), 32'd15);

        // Three mispredicted taken updates on one PC.
        upd_valid_i   = 1'b1;
        upd_pc_i      = 32'h8060;
        upd_taken_i   = 1'b1;
        upd_target_i  = 32'hC000;
        upd_mispred_i = 1'b1;
        repeat (3) tick();
        idle_inputs();
        pc_i = 32'h8060;
        #1;
        check("mispred_3", 32'(stat_mispred_o), 32'd3);
        check_pred("pre_reset", 1'b1, 1'b1, 32'hC000);

        // Reset mid-run overrides a same-cycle update and lookup.
        rst           = 1'b1;
        lookup_en_i   = 1'b1;
        upd_valid_i   = 1'b1;
        upd_pc_i      = 32'h8070;
        upd_taken_i   = 1'b1;
        upd_target_i  = 32'hD000;
        upd_mispred_i = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        pc_i = 32'h8060;
        #1;
        check_pred("post_reset_a", 1'b0, 1'b0, 32'h8064);
        pc_i = 32'h8070;
        #1;
        check_pred("post_reset_b", 1'b0, 1'b0, 32'h8074);
        check("post_reset_lookups", 32'(stat_lookups_o), 32'd0);
        check("post_reset_mispred", 32'(stat_mispred_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
